// File: rtl/ooo_pkg.sv
// Shared out-of-order core types used by the writeback path.
//   DATA_WIDTH / PREG_WIDTH / ROB_WIDTH : datapath widths
//   wb_req_t : one completed result {dest, data, rob}
//   wb_src_e : writeback source index, also the round-robin scan order
package ooo_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned PREG_WIDTH = 7;
   localparam int unsigned ROB_WIDTH  = 5;
   localparam int unsigned NUM_SRC    = 3;

   typedef struct packed {
      logic [PREG_WIDTH-1:0] dest;
      logic [DATA_WIDTH-1:0] data;
      logic [ROB_WIDTH-1:0]  rob;
   } wb_req_t;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_BR  = 2'd1,
      SRC_LSU = 2'd2
   } wb_src_e;

   // Successor in the ALU -> BR -> LSU -> ALU ring.
   function automatic wb_src_e next_src(input wb_src_e s);
      case (s)
         SRC_ALU: return SRC_BR;
         SRC_BR:  return SRC_LSU;
         default: return SRC_ALU;
      endcase
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Single-source result FIFO (circular buffer) in front of the writeback arbiter.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   flush             : synchronous clear; also drops a same-cycle push and pop
//   push_valid/ready  : producer handshake; ready depends on the count register only
//   push_data         : result to enqueue
//   pop               : dequeue the head (ignored when empty)
//   head              : oldest entry
//   count             : current occupancy
module wb_fifo
   import ooo_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push_valid,
   output logic             push_ready,
   input  wb_req_t          push_data,
   input  logic             pop,
   output wb_req_t          head,
   output logic [CNT_W-1:0] count
);

   wb_req_t          mem_q [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   assign push_ready = (count_q < CNT_W'(DEPTH));
   assign do_push    = push_valid && push_ready && !flush;
   assign do_pop     = pop && (count_q != '0) && !flush;

   // DEPTH is a power of two, so pointer increments wrap on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + PTR_W'(1);
         if (do_pop)  head_q <= head_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= push_data;
   end

   assign head  = mem_q[head_q];
   assign count = count_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers results from ALU, branch-link and LSU in per-source FIFOs and
// retires up to two per cycle onto the PRF write ports, round-robin between sources.
// The registered write ports are also the CDB broadcast (ROB completion, IQ wakeup).
// Ports:
//   clk, reset                   : clock, asynchronous active-high reset
//   flush                        : synchronous mispredict flush (drops everything in flight)
//   {alu,br,lsu}_req_valid/ready : per-source push handshake
//   {alu,br,lsu}_req_dest/data/rob : per-source result payload
//   wb{0,1}_valid/dest/data/rob  : registered write ports; wb1 only used when wb0 is
module writeback_arbiter #(
   parameter int unsigned DATA_WIDTH = ooo_pkg::DATA_WIDTH,
   parameter int unsigned PREG_WIDTH = ooo_pkg::PREG_WIDTH,
   parameter int unsigned ROB_WIDTH  = ooo_pkg::ROB_WIDTH,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  alu_req_valid,
   output logic                  alu_req_ready,
   input  logic [PREG_WIDTH-1:0] alu_req_dest,
   input  logic [DATA_WIDTH-1:0] alu_req_data,
   input  logic [ROB_WIDTH-1:0]  alu_req_rob,
   input  logic                  br_req_valid,
   output logic                  br_req_ready,
   input  logic [PREG_WIDTH-1:0] br_req_dest,
   input  logic [DATA_WIDTH-1:0] br_req_data,
   input  logic [ROB_WIDTH-1:0]  br_req_rob,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [PREG_WIDTH-1:0] lsu_req_dest,
   input  logic [DATA_WIDTH-1:0] lsu_req_data,
   input  logic [ROB_WIDTH-1:0]  lsu_req_rob,
   output logic                  wb0_valid,
   output logic [PREG_WIDTH-1:0] wb0_dest,
   output logic [DATA_WIDTH-1:0] wb0_data,
   output logic [ROB_WIDTH-1:0]  wb0_rob,
   output logic                  wb1_valid,
   output logic [PREG_WIDTH-1:0] wb1_dest,
   output logic [DATA_WIDTH-1:0] wb1_data,
   output logic [ROB_WIDTH-1:0]  wb1_rob
);

   // Width parameters must match the ooo_pkg constants that size wb_req_t.
   import ooo_pkg::*;

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   wb_req_t              push_data  [NUM_SRC];
   wb_req_t              head       [NUM_SRC];
   logic [CNT_W-1:0]     fifo_count [NUM_SRC];
   logic [NUM_SRC-1:0]   push_valid;
   logic [NUM_SRC-1:0]   push_ready;
   logic [NUM_SRC-1:0]   pop;
   logic [NUM_SRC-1:0]   eligible;

   wb_src_e rr_q, rr_d;
   wb_src_e src0, src1;
   logic    grant0, grant1;
   wb_req_t wb0_q, wb1_q;
   logic    wb0_valid_q, wb1_valid_q;

   assign push_valid = {lsu_req_valid, br_req_valid, alu_req_valid};
   assign push_data[SRC_ALU] = '{dest: alu_req_dest, data: alu_req_data, rob: alu_req_rob};
   assign push_data[SRC_BR]  = '{dest: br_req_dest,  data: br_req_data,  rob: br_req_rob};
   assign push_data[SRC_LSU] = '{dest: lsu_req_dest, data: lsu_req_data, rob: lsu_req_rob};

   assign alu_req_ready = push_ready[SRC_ALU];
   assign br_req_ready  = push_ready[SRC_BR];
   assign lsu_req_ready = push_ready[SRC_LSU];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
      wb_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk        (clk),
         .reset      (reset),
         .flush      (flush),
         .push_valid (push_valid[i]),
         .push_ready (push_ready[i]),
         .push_data  (push_data[i]),
         .pop        (pop[i]),
         .head       (head[i]),
         .count      (fifo_count[i])
      );
      assign eligible[i] = (fifo_count[i] != '0);
   end

   // Walk the ring from rr_q; first eligible source -> wb0, second -> wb1. Each source is
   // visited once, so it can win at most one port per cycle.
   always_comb begin
      wb_src_e idx;
      grant0 = 1'b0;
      grant1 = 1'b0;
      src0   = SRC_ALU;
      src1   = SRC_ALU;
      pop    = '0;
      rr_d   = rr_q;
      idx    = rr_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (eligible[idx] && !flush) begin
            if (!grant0) begin
               grant0 = 1'b1;
               src0   = idx;
            end else if (!grant1) begin
               grant1 = 1'b1;
               src1   = idx;
            end
         end
         idx = next_src(idx);
      end
      if (grant0) pop[src0] = 1'b1;
      if (grant1) pop[src1] = 1'b1;
      if (grant1) begin
         rr_d = next_src(src1);
      end else if (grant0) begin
         rr_d = next_src(src0);
      end
   end

   // Payload regs hold on idle cycles; only valid drops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q        <= SRC_ALU;
         wb0_valid_q <= 1'b0;
         wb1_valid_q <= 1'b0;
         wb0_q       <= '0;
         wb1_q       <= '0;
      end else begin
         rr_q        <= rr_d;
         wb0_valid_q <= grant0;
         wb1_valid_q <= grant1;
         if (grant0) wb0_q <= head[src0];
         if (grant1) wb1_q <= head[src1];
      end
   end

   assign wb0_valid = wb0_valid_q;
   assign wb0_dest  = wb0_q.dest;
   assign wb0_data  = wb0_q.data;
   assign wb0_rob   = wb0_q.rob;
   assign wb1_valid = wb1_valid_q;
   assign wb1_dest  = wb1_q.dest;
   assign wb1_data  = wb1_q.data;
   assign wb1_rob   = wb1_q.rob;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        alu_req_valid, br_req_valid, lsu_req_valid;
   logic        alu_req_ready, br_req_ready, lsu_req_ready;
   logic [6:0]  alu_req_dest, br_req_dest, lsu_req_dest;
   logic [31:0] alu_req_data, br_req_data, lsu_req_data;
   logic [4:0]  alu_req_rob, br_req_rob, lsu_req_rob;
   logic        wb0_valid, wb1_valid;
   logic [6:0]  wb0_dest, wb1_dest;
   logic [31:0] wb0_data, wb1_data;
   logic [4:0]  wb0_rob, wb1_rob;

   writeback_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .alu_req_valid (alu_req_valid),
      .alu_req_ready (alu_req_ready),
      .alu_req_dest  (alu_req_dest),
      .alu_req_data  (alu_req_data),
      .alu_req_rob   (alu_req_rob),
      .br_req_valid  (br_req_valid),
      .br_req_ready  (br_req_ready),
      .br_req_dest   (br_req_dest),
      .br_req_data   (br_req_data),
      .br_req_rob    (br_req_rob),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_req_dest  (lsu_req_dest),
      .lsu_req_data  (lsu_req_data),
      .lsu_req_rob   (lsu_req_rob),
      .wb0_valid     (wb0_valid),
      .wb0_dest      (wb0_dest),
      .wb0_data      (wb0_data),
      .wb0_rob       (wb0_rob),
      .wb1_valid     (wb1_valid),
      .wb1_dest      (wb1_dest),
      .wb1_data      (wb1_data),
      .wb1_rob       (wb1_rob)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  dest;
      logic [31:0] data;
      logic [4:0]  rob;
   } item_t;

   item_t pend [3][$];
   item_t expq [3][$];

   int n_tests = 0;
   int n_fail  = 0;
   int recv    = 0;
   int grants   [3];
   int idle     [3];
   int max_idle [3];
   bit lsu_stalled = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_reqs();
      alu_req_valid = 1'b0; alu_req_dest = '0; alu_req_data = '0; alu_req_rob = '0;
      br_req_valid  = 1'b0; br_req_dest  = '0; br_req_data  = '0; br_req_rob  = '0;
      lsu_req_valid = 1'b0; lsu_req_dest = '0; lsu_req_data = '0; lsu_req_rob = '0;
   endtask

   task automatic reset_pulse();
      clr_reqs();
      flush = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int s = 0; s < 3; s++) begin
         pend[s].delete();
         expq[s].delete();
      end
   endtask

   // Results carry their source in data[31:28] and a sequence number below.
   task automatic load_items(input int src, input int n);
      item_t it;
      for (int k = 0; k < n; k++) begin
         it.dest = 7'(src * 40 + k + 1);
         it.data = {4'(src), 28'(k)};
         it.rob  = 5'(k);
         pend[src].push_back(it);
      end
   endtask

   task automatic drive_pend();
      clr_reqs();
      if (pend[0].size() != 0) begin
         alu_req_valid = 1'b1; alu_req_dest = pend[0][0].dest;
         alu_req_data  = pend[0][0].data; alu_req_rob = pend[0][0].rob;
      end
      if (pend[1].size() != 0) begin
         br_req_valid = 1'b1; br_req_dest = pend[1][0].dest;
         br_req_data  = pend[1][0].data; br_req_rob = pend[1][0].rob;
      end
      if (pend[2].size() != 0) begin
         lsu_req_valid = 1'b1; lsu_req_dest = pend[2][0].dest;
         lsu_req_data  = pend[2][0].data; lsu_req_rob = pend[2][0].rob;
      end
   endtask

   task automatic check_port(input logic v, input logic [6:0] d, input logic [31:0] dat,
                             input logic [4:0] r, input string tag, output logic [2:0] got);
      int    s;
      item_t it;
      got = '0;
      if (v) begin
         s = int'(dat[31:28]);
         check_eq({tag, "_known_src"}, 64'(s < 3 && expq[s % 4 < 3 ? s : 0].size() != 0), 1);
         if (s < 3 && expq[s].size() != 0) begin
            it = expq[s].pop_front();
            got[s] = 1'b1;
            recv++;
            check_eq({tag, "_dest"}, 64'(d), 64'(it.dest));
            check_eq({tag, "_data"}, 64'(dat), 64'(it.data));
            check_eq({tag, "_rob"},  64'(r), 64'(it.rob));
         end
      end
   endtask

   task automatic sb_cycle(input bit count_en);
      logic [2:0] vld, rdy, g0, g1;
      drive_pend();
      vld = {lsu_req_valid, br_req_valid, alu_req_valid};
      rdy = {lsu_req_ready, br_req_ready, alu_req_ready};
      if (lsu_req_valid && !lsu_req_ready) lsu_stalled = 1'b1;
      tick();
      for (int s = 0; s < 3; s++) begin
         if (vld[s] && rdy[s]) expq[s].push_back(pend[s].pop_front());
      end
      check_port(wb0_valid, wb0_dest, wb0_data, wb0_rob, "wb0", g0);
      check_port(wb1_valid, wb1_dest, wb1_data, wb1_rob, "wb1", g1);
      if (wb1_valid) check_eq("wb1_implies_wb0", 64'(wb0_valid), 1);
      if (count_en) begin
         check_eq("sat_same_src_twice", 64'(g0 & g1), 0);
         for (int s = 0; s < 3; s++) begin
            if (g0[s] || g1[s]) begin
               grants[s]++;
               idle[s] = 0;
            end else begin
               idle[s]++;
               if (idle[s] > max_idle[s]) max_idle[s] = idle[s];
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_reqs();
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      check_eq("rst_wb0_valid", 64'(wb0_valid), 0);
      check_eq("rst_wb1_valid", 64'(wb1_valid), 0);
      check_eq("rst_wb0_dest",  64'(wb0_dest), 0);
      check_eq("rst_wb0_data",  64'(wb0_data), 0);
      check_eq("rst_wb1_rob",   64'(wb1_rob), 0);
      check_eq("rst_ready", 64'({alu_req_ready, br_req_ready, lsu_req_ready}), 64'(3'b111));
      reset = 1'b0;
      tick();

      // Single ALU push, then a three-way push with rr_ptr at BR
      alu_req_valid = 1'b1; alu_req_dest = 7'd5; alu_req_data = 32'hDEAD_BEEF;
      alu_req_rob = 5'd3;
      tick();
      clr_reqs();
      check_eq("t1_no_bypass", 64'(wb0_valid), 0);
      tick();
      check_eq("t1_wb0_valid", 64'(wb0_valid), 1);
      check_eq("t1_wb0_dest",  64'(wb0_dest), 5);
      check_eq("t1_wb0_data",  64'(wb0_data), 64'h0000_0000_DEAD_BEEF);
      check_eq("t1_wb0_rob",   64'(wb0_rob), 3);
      check_eq("t1_wb1_valid", 64'(wb1_valid), 0);
      alu_req_valid = 1'b1; alu_req_dest = 7'd10; alu_req_data = 32'h10; alu_req_rob = 5'd10;
      br_req_valid  = 1'b1; br_req_dest  = 7'd11; br_req_data  = 32'h11; br_req_rob  = 5'd11;
      lsu_req_valid = 1'b1; lsu_req_dest = 7'd12; lsu_req_data = 32'h12; lsu_req_rob = 5'd12;
      tick();
      clr_reqs();
      check_eq("t1_idle_valid", 64'(wb0_valid), 0);
      check_eq("t1_idle_hold",  64'(wb0_dest), 5);
      tick();
      check_eq("rr1_wb0_dest", 64'(wb0_dest), 11);
      check_eq("rr1_wb1_dest", 64'(wb1_dest), 12);
      check_eq("rr1_wb1_valid", 64'(wb1_valid), 1);
      tick();
      check_eq("rr1_wb0_dest2", 64'(wb0_dest), 10);
      check_eq("rr1_wb1_valid2", 64'(wb1_valid), 0);

      // Three-way push from rr_ptr = ALU
      reset_pulse();
      alu_req_valid = 1'b1; alu_req_dest = 7'd10; alu_req_data = 32'h10; alu_req_rob = 5'd10;
      br_req_valid  = 1'b1; br_req_dest  = 7'd11; br_req_data  = 32'h11; br_req_rob  = 5'd11;
      lsu_req_valid = 1'b1; lsu_req_dest = 7'd12; lsu_req_data = 32'h12; lsu_req_rob = 5'd12;
      tick();
      clr_reqs();
      tick();
      check_eq("rr0_wb0_dest", 64'(wb0_dest), 10);
      check_eq("rr0_wb1_dest", 64'(wb1_dest), 11);
      check_eq("rr0_wb1_rob",  64'(wb1_rob), 11);
      tick();
      check_eq("rr0_wb0_dest2", 64'(wb0_dest), 12);
      check_eq("rr0_wb0_valid2", 64'(wb0_valid), 1);
      check_eq("rr0_wb1_valid2", 64'(wb1_valid), 0);

      // LSU held valid against ALU+BR traffic
      reset_pulse();
      recv = 0;
      load_items(0, 3);
      load_items(1, 3);
      load_items(2, 4);
      for (int c = 0; c < 20; c++) begin
         if (pend[0].size() + pend[1].size() + pend[2].size() +
             expq[0].size() + expq[1].size() + expq[2].size() == 0) break;
         sb_cycle(1'b0);
      end
      check_eq("bp_lsu_ready_dropped", 64'(lsu_stalled), 1);
      check_eq("bp_all_received", 64'(recv), 10);
      check_eq("bp_drained", 64'(pend[2].size() + expq[2].size()), 0);

      // Saturation for 30 cycles
      reset_pulse();
      for (int s = 0; s < 3; s++) begin
         grants[s] = 0; idle[s] = 0; max_idle[s] = 0;
         load_items(s, 40);
      end
      sb_cycle(1'b0);
      for (int c = 0; c < 30; c++) sb_cycle(1'b1);
      check_eq("sat_grants_alu", 64'(grants[0]), 20);
      check_eq("sat_grants_br",  64'(grants[1]), 20);
      check_eq("sat_grants_lsu", 64'(grants[2]), 20);
      check_eq("sat_max_idle_alu", 64'(max_idle[0]), 1);
      check_eq("sat_max_idle_br",  64'(max_idle[1]), 1);
      check_eq("sat_max_idle_lsu", 64'(max_idle[2]), 1);
      for (int s = 0; s < 3; s++) pend[s].delete();
      for (int c = 0; c < 10; c++) begin
         if (expq[0].size() + expq[1].size() + expq[2].size() == 0) break;
         sb_cycle(1'b0);
      end
      check_eq("sat_drained", 64'(expq[0].size() + expq[1].size() + expq[2].size()), 0);

      // Flush with FIFOs loaded and a concurrent ALU push
      reset_pulse();
      load_items(0, 3);
      load_items(1, 3);
      load_items(2, 3);
      for (int c = 0; c < 3; c++) sb_cycle(1'b0);
      for (int s = 0; s < 3; s++) begin
         pend[s].delete();
         expq[s].delete();
      end
      clr_reqs();
      alu_req_valid = 1'b1; alu_req_dest = 7'h33; alu_req_data = 32'hBAD0_0033;
      alu_req_rob = 5'd17;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      clr_reqs();
      check_eq("fl_wb0_valid", 64'(wb0_valid), 0);
      check_eq("fl_wb1_valid", 64'(wb1_valid), 0);
      check_eq("fl_ready", 64'({alu_req_ready, br_req_ready, lsu_req_ready}), 64'(3'b111));
      for (int c = 0; c < 3; c++) begin
         tick();
         check_eq("fl_nothing_out", 64'({wb0_valid, wb1_valid}), 0);
      end

      // Asynchronous reset mid-cycle, then dest==0 branch completion
      reset_pulse();
      alu_req_valid = 1'b1; alu_req_dest = 7'd7; alu_req_data = 32'h7; alu_req_rob = 5'd1;
      br_req_valid  = 1'b1; br_req_dest  = 7'd8; br_req_data  = 32'h8; br_req_rob  = 5'd2;
      tick();
      clr_reqs();
      tick();
      check_eq("ar_pre_valid", 64'({wb0_valid, wb1_valid}), 64'(2'b11));
      #2;
      reset = 1'b1;
      #1;
      check_eq("ar_wb0_valid", 64'(wb0_valid), 0);
      check_eq("ar_wb1_valid", 64'(wb1_valid), 0);
      check_eq("ar_wb0_dest",  64'(wb0_dest), 0);
      tick();
      reset = 1'b0;
      br_req_valid = 1'b1; br_req_dest = 7'd0; br_req_data = 32'h0000_1234; br_req_rob = 5'd7;
      tick();
      clr_reqs();
      tick();
      check_eq("p0_wb0_valid", 64'(wb0_valid), 1);
      check_eq("p0_wb0_dest",  64'(wb0_dest), 0);
      check_eq("p0_wb0_rob",   64'(wb0_rob), 7);
      check_eq("p0_wb0_data",  64'(wb0_data), 64'h1234);
      check_eq("p0_wb1_valid", 64'(wb1_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
